// File: rtl/mod_counter_n.sv
// mod_counter_n: parametrised synchronous modulo-N up/down counter.
// 161-style ENP/ENT gating and RCO, so stages cascade into wider counters.
// Adds a count-direction input, a registered wrap pulse, a sticky wrap flag
// with acknowledge, and a registered out-of-range load pulse.
module mod_counter_n #(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    input  logic             wrap_ack,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             tc,
    output logic             wrap,
    output logic             wrap_flag,
    output logic             load_err
);

    // MODULUS is a longint so that MODULUS = 2^32 is representable at WIDTH = 32.
    generate
        if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
            MODULUS > (longint'(1) << WIDTH)) begin : g_bad_params
            $error("mod_counter_n: WIDTH must be 1..32 and MODULUS 2..2^WIDTH");
        end
    endgenerate

    // Highest legal count. When MODULUS = 2^WIDTH this is all ones, so the
    // wrap coincides with natural binary rollover.
    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_Q = '0;
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             load_err_next;
    logic             wrap_flag_next;
    logic             count_en;

    // Terminal count follows the current direction combinationally; ent gates
    // only the carry out, which keeps ent->rco a single AND for cascading.
    assign tc       = up ? (q == MAX_Q) : (q == ZERO_Q);
    assign rco      = ent & tc;
    assign count_en = enp & ent;

    // Next-state selection with priority clr > load > count > hold.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the if/else chain can leave a variable unassigned (no latch).
        q_next         = q;
        wrap_next      = 1'b0;
        load_err_next  = 1'b0;
        wrap_flag_next = wrap_flag;

        if (clr) begin
            q_next = ZERO_Q;
        end else if (load) begin
            // Out-of-range data clamps to the top legal value so q never
            // holds a value >= MODULUS.
            if (d <= MAX_Q) begin
                q_next = d;
            end else begin
                q_next        = MAX_Q;
                load_err_next = 1'b1;
            end
        end else if (count_en) begin
            if (up) begin
                q_next = (q == MAX_Q) ? ZERO_Q : q + ONE_Q;
            end else begin
                q_next = (q == ZERO_Q) ? MAX_Q : q - ONE_Q;
            end
            wrap_next = tc;
        end

        // Setting the sticky flag takes precedence over a simultaneous ack.
        if (wrap_next) begin
            wrap_flag_next = 1'b1;
        end else if (wrap_ack) begin
            wrap_flag_next = 1'b0;
        end
    end

    // State register with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs, independent of statement order.
        if (rst) begin
            q         <= ZERO_Q;
            wrap      <= 1'b0;
            wrap_flag <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            q         <= q_next;
            wrap      <= wrap_next;
            wrap_flag <= wrap_flag_next;
            load_err  <= load_err_next;
        end
    end

endmodule

// File: doc/mod_counter_n.md
# mod_counter_n

Parametrised synchronous modulo-N up/down counter, the successor to our 4-bit 74LS161-style counter. Generalises width and modulus, adds a count-direction mode, a registered wrap pulse and a sticky wrap flag with acknowledge, and keeps 161-style ENP/ENT gating and RCO so instances cascade into wider counters. Used as the timebase and digit counter in the lab top-levels. It drives the display and scan logic directly.

## Interface
- WIDTH, 4: counter width in bits; legal range 1..32.
- MODULUS, 16: count modulus; legal range 2..2^WIDTH. Elaboration fails outside this range.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of the count only, active-high.
- load  in  1  synchronous parallel load, active-high.
- d  in  WIDTH  parallel load data.
- enp  in  1  count enable P; no effect on rco.
- ent  in  1  count enable T; gates rco.
- up  in  1  direction: 1 = increment, 0 = decrement.
- wrap_ack  in  1  clears wrap_flag.
- q  out  WIDTH  current count, registered.
- rco  out  1  ripple carry out, combinational: ent & tc.
- tc  out  1  terminal count, combinational: (up & q==MODULUS-1) | (!up & q==0).
- wrap  out  1  registered one-cycle pulse, high the cycle after a counting wrap.
- wrap_flag  out  1  sticky wrap indicator.
- load_err  out  1  registered one-cycle pulse, high the cycle after an out-of-range load.

## Operation
- Priority per edge: rst > clr > load > count > hold.
- rst: q=0, wrap=0, wrap_flag=0, load_err=0.
- clr: q=0, wrap=0, load_err=0. wrap_flag is unchanged.
- load: if d < MODULUS, q=d and load_err=0. Otherwise q=MODULUS-1 and load_err=1. Load ignores enp, ent and up. wrap=0.
- count (enp & ent, no higher-priority input):
  - Up: q = (q==MODULUS-1) ? 0 : q+1.
  - Down: q = (q==0) ? MODULUS-1 : q-1.
  - wrap = tc. A wrap is the transition from the terminal value.
- hold (enp=0 or ent=0): q unchanged, wrap=0, load_err=0.
- wrap_flag:
  - Set in the cycle wrap is being set.
  - Otherwise cleared by wrap_ack.
  - Simultaneous set and ack: set wins.
  - Cleared only by rst or wrap_ack.
- Counter arithmetic is WIDTH bits with no intermediate overflow. When MODULUS=2^WIDTH the wrap equals natural binary rollover.
- q never holds a value ≥ MODULUS, regardless of input sequence.
- Direction may change on any cycle. tc and rco follow the current up value combinationally.
- Cascade: connect the low stage's rco to the high stage's ent. Tie enp on all stages to the global enable. Wide counts then advance in one clock with no extra latency.

## Timing
- Latency of q from clr, load or count: 1 cycle.
- wrap and load_err are high exactly 1 cycle, in the cycle after the causing edge is sampled. This is the same cycle q shows the wrapped or clamped value.
- wrap_flag rises with wrap and clears the cycle after wrap_ack is sampled.
- rco and tc are combinational from q, up and ent, with no register stage. The ent→rco path is the cascade critical path.
- After rst deasserts, the first count can occur on the next edge.
- Reset mid-count or mid-load: rst wins outright. All outputs return to reset values on that edge.

## Test plan
- Reset: rst=1 for 2 cycles from arbitrary state → q=0, wrap=0, wrap_flag=0, load_err=0. Then enp=ent=up=1 for 3 cycles → q=1,2,3.
- Modulo wrap up (WIDTH=4, MODULUS=10): count from 0 for 10 cycles → q reaches 9 with tc=1 and rco=1, then q=0. wrap is high that one cycle and wrap_flag=1. Assert wrap_ack → wrap_flag=0 next cycle.
- Down wrap plus ack collision (MODULUS=10): load 0, up=0, count once while wrap_ack=1 → q=9, wrap=1, wrap_flag=1 (set wins).
- Load and priority (MODULUS=10):
  - load d=7 → q=7, load_err=0.
  - load d=12 → q=9, load_err=1 for 1 cycle.
  - clr and load together → q=0.
  - ent=0 with enp=1 → q holds, rco=0.
- Cascade: two WIDTH=4, MODULUS=16 instances with the low stage's rco driving the high stage's ent, counting from 0x0F → next edge gives 0x10, and wrap pulses only on the low stage. From 0xFF → 0x00, and both stages pulse wrap together.
- Boundary (WIDTH=1, MODULUS=2): up count toggles 0,1,0 with wrap every second cycle. Down count from 0 gives 1 with wrap=1.
